// File: rtl/serial_paralelo_sync.sv
// Receive end of the serial lane: comma alignment, sync qualification and
// byte delivery for a MSB-first bit stream clocked at the bit rate.
module serial_paralelo_sync #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter logic [7:0]  IDLE        = 8'h7C,
    parameter int unsigned SYNC_COMMAS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] out_byte,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active,
    output logic [1:0] state_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ALIGNED = 2'd1,
        ACTIVE  = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [BYTE_W-1:0]  sr_q,        sr_d;
    logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]   comma_cnt_q, comma_cnt_d;
    logic [BYTE_W-1:0]  out_byte_q,  out_byte_d;
    logic               valid_q,     valid_d;
    logic               stb_q,       stb_d;
    logic               active_q,    active_d;

    logic [BYTE_W-1:0]  win;
    logic [CNT_W-1:0]   comma_inc;
    logic               is_comma;
    logic               is_idle;
    logic               boundary;

    // Byte completed by the bit arriving on this edge.
    always_comb begin
        win       = {sr_q[BYTE_W-2:0], data_in};
        is_comma  = (win == COMMA);
        is_idle   = (win == IDLE);
        boundary  = (bit_cnt_q == BIT_W'(7));
        comma_inc = comma_cnt_q + CNT_W'(1);
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        sr_d        = win;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        out_byte_d  = out_byte_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;
        active_d    = active_q;

        case (state_q)
            SEARCH: begin
                // Sliding match: any bit offset may carry the comma.
                if (is_comma) begin
                    state_d     = ALIGNED;
                    bit_cnt_d   = '0;
                    comma_cnt_d = CNT_W'(1);
                end
            end

            ALIGNED: begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_inc;
                        if (comma_inc == CNT_W'(SYNC_COMMAS)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d     = SEARCH;
                        comma_cnt_d = '0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (boundary) begin
                    stb_d = 1'b1;
                    if (is_comma || is_idle) begin
                        valid_d = 1'b0;
                    end else begin
                        out_byte_d = win;
                        valid_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            out_byte_q  <= '0;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            out_byte_q  <= out_byte_d;
            valid_q     <= valid_d;
            stb_q       <= stb_d;
            active_q    <= active_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign valid_out = valid_q;
    assign byte_stb  = stb_q;
    assign active    = active_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Bench for serial_paralelo_sync: vector table, hand-written corner cases and
// randomized streams checked against a bit-level behavioural model.
module tb_serial_paralelo_sync;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] IDLE  = 8'h7C;
    localparam int         SYNC  = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] out_byte;
    logic       valid_out;
    logic       byte_stb;
    logic       active;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;
    int ndata    = 0;

    serial_paralelo_sync #(
        .COMMA      (COMMA),
        .IDLE       (IDLE),
        .SYNC_COMMAS(SYNC)
    ) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .out_byte (out_byte),
        .valid_out(valid_out),
        .byte_stb (byte_stb),
        .active   (active),
        .state_o  (state_o)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: mode 0 hunting, 1 counting commas, 2 delivering.
    // Byte slots are derived from the absolute bit index of the last aligning comma.
    int         m_mode;
    int         m_cnt;
    longint     m_t;
    longint     m_align;
    logic [7:0] m_win;
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_stb;
    logic       m_act;

    function automatic void model_reset();
        m_mode = 0; m_cnt = 0; m_t = 0; m_align = 0;
        m_win = 8'h00; m_out = 8'h00; m_valid = 1'b0; m_stb = 1'b0; m_act = 1'b0;
    endfunction

    function automatic void model_bit(input logic b);
        m_win = {m_win[6:0], b};
        m_t   = m_t + 1;
        m_stb = 1'b0;
        if (m_mode == 0) begin
            if (m_win == COMMA) begin
                m_mode = 1; m_align = m_t; m_cnt = 1;
            end
        end else if (((m_t - m_align) % 8) == 0) begin
            if (m_mode == 1) begin
                if (m_win == COMMA) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == SYNC) begin
                        m_mode = 2; m_act = 1'b1;
                    end
                end else begin
                    m_mode = 0; m_cnt = 0;
                end
            end else begin
                m_stb = 1'b1;
                if (m_win == COMMA || m_win == IDLE) begin
                    m_valid = 1'b0;
                end else begin
                    m_out = m_win; m_valid = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [12:0] dut_vec();
        return {out_byte, valid_out, byte_stb, active, state_o};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_out, m_valid, m_stb, m_act, 2'(m_mode)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_bit(b);
        chk("edge", 32'(dut_vec()), 32'(model_vec()));
        if (byte_stb && valid_out) ndata = ndata + 1;
        @(negedge clk_32f);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("reset_async", 32'(dut_vec()), 32'(model_vec()));
        @(posedge clk_32f);
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          off;
        logic [7:0]  exp_out;
        logic        exp_valid;
        logic        exp_act;
        logic [1:0]  exp_state;
        int          exp_ndata;
    } vec_t;

    localparam int NV = 6;
    vec_t       vecs [NV];
    logic [8:0] exp3 [4];
    logic [7:0] seq3 [4];
    logic [7:0] bt;
    logic [6:0] w7;
    logic       rb;

    initial begin
        vecs[0] = '{64'hBCBCBCBC_A53C0000, 6, 3, 8'h3C, 1'b1, 1'b1, 2'd2, 2};
        vecs[1] = '{64'hBCBC42BC_BCBCBC11, 8, 0, 8'h11, 1'b1, 1'b1, 2'd2, 1};
        vecs[2] = '{64'hBCBCBCBC_55BC7CAA, 8, 1, 8'hAA, 1'b1, 1'b1, 2'd2, 2};
        vecs[3] = '{64'hBCBCBC00_00000000, 6, 2, 8'h00, 1'b0, 1'b0, 2'd0, 0};
        vecs[4] = '{64'h7CBCBCBC_BC7CC300, 7, 5, 8'hC3, 1'b1, 1'b1, 2'd2, 1};
        vecs[5] = '{64'hBCBCBCBC_BCBCBCBC, 8, 0, 8'h00, 1'b0, 1'b1, 2'd2, 0};
        exp3 = '{9'h155, 9'h055, 9'h055, 9'h1AA};
        seq3 = '{8'h55, 8'hBC, 8'h7C, 8'hAA};

        @(negedge clk_32f);
        do_reset();

        // Table-driven streams.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            ndata = 0;
            for (int i = 0; i < vecs[v].off; i++) send_bit(1'b0);
            for (int i = 0; i < vecs[v].n; i++) begin
                bt = 8'(vecs[v].bytes >> (56 - 8 * i));
                send_byte(bt);
            end
            chk($sformatf("vec%0d_final", v), 32'({out_byte, valid_out, active, state_o}),
                32'({vecs[v].exp_out, vecs[v].exp_valid, vecs[v].exp_act, vecs[v].exp_state}));
            chk($sformatf("vec%0d_ndata", v), 32'(ndata), 32'(vecs[v].exp_ndata));
        end

        // Filtering of commas and idles with out_byte held.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        chk("sync_active", 32'(active), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(seq3[i]);
            chk($sformatf("filter%0d", i), 32'({valid_out, out_byte}), 32'(exp3[i]));
        end

        // Reset in the middle of a byte while active.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midbyte_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        @(posedge clk_32f);
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        chk("resync_3", 32'(active), 32'd0);
        send_byte(COMMA);
        chk("resync_4", 32'({active, state_o}), 32'({1'b1, 2'd2}));

        // Comma-free random data never leaves SEARCH.
        do_reset();
        w7 = 7'd0;
        for (int i = 0; i < 1000; i++) begin
            rb = 1'($urandom);
            if ({w7, rb} == COMMA) rb = ~rb;
            w7 = {w7[5:0], rb};
            send_bit(rb);
        end
        chk("nocomma_idle", 32'(dut_vec()), 32'd0);

        // Random sync runs with random payload.
        for (int it = 0; it < 30; it++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) send_bit(1'($urandom));
            for (int i = 0; i < int'($urandom_range(2, 6)); i++) send_byte(COMMA);
            for (int i = 0; i < 6; i++) begin
                case ($urandom_range(0, 7))
                    0:       bt = COMMA;
                    1:       bt = IDLE;
                    default: bt = 8'($urandom);
                endcase
                send_byte(bt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
